// File: rtl/nonce_sched_pkg.sv
// Shared types and constants for the nonce sweep scheduler.
// Index width is derived from the core count through idx_w().
package nonce_sched_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [31:0] MIN_HASH_INIT = 32'hFFFFFFFF;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nonce_sched_rr_arbiter.sv
// Round-robin arbiter with one-hot grant and a last-grant pointer.
// The search starts after the last winner, or at index 0 out of reset.
module rr_arbiter
  import nonce_sched_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] last
);

  logic          have;
  logic [IW-1:0] first;
  logic [IW-1:0] gidx;
  int            j;

  // Scan downward so the index closest to 'first' wins.
  always_comb begin
    first = '0;
    if (have && int'(last) < N - 1) first = last + 1'b1;
    gnt  = '0;
    gidx = '0;
    j    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(first) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        gidx   = IW'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have <= 1'b0;
      last <= '0;
    end else if (adv && (|req)) begin
      have <= 1'b1;
      last <= gidx;
    end
  end

endmodule

// File: rtl/nonce_sched.sv
// Nonce sweep scheduler: dispatches nonces to hash cores, writes H0 results.
// Optional NONCE_SCHED_MIN_TRACK_EN adds min_hash/min_nonce tracking.
module nonce_sched
  import nonce_sched_pkg::*;
#(
  parameter int NUM_NONCES = 16,
  parameter int INSTANCES  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [15:0]            hash_out_addr,
  output logic                   done,
  output logic [INSTANCES-1:0]   req_valid,
  input  logic [INSTANCES-1:0]   req_ready,
  output logic [31:0]            req_nonce,
  input  logic [INSTANCES-1:0]   res_valid,
  input  logic [32*INSTANCES-1:0] res_data,
  output logic [INSTANCES-1:0]   res_ready,
  output logic                   mem_we,
  output logic [15:0]            memory_addr,
  output logic [31:0]            memory_write_data,
`ifdef NONCE_SCHED_MIN_TRACK_EN
  output logic [31:0]            min_hash,
  output logic [31:0]            min_nonce,
`endif
  output logic                   protocol_err
);

  localparam int IW = idx_w(INSTANCES);
  localparam int CW = 17;
  localparam logic [CW-1:0] NN = CW'(NUM_NONCES);

  state_t state, state_n;

  logic [15:0]          base;
  logic [CW-1:0]        next_nonce;
  logic [CW-1:0]        written;
  logic [INSTANCES-1:0] busy;
  logic [15:0]          tag [INSTANCES];
  logic                 offer_act;
  logic [IW-1:0]        offer_idx;
  logic                 free_any;
  logic [IW-1:0]        free_idx;
  logic                 offer_on;
  logic [IW-1:0]        offer_sel;
  logic                 xfer;
  logic [INSTANCES-1:0] arb_req;
  logic [INSTANCES-1:0] gnt;
  logic [IW-1:0]        last;
  logic                 accept;
  logic [31:0]          acc_data;

  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = INSTANCES - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  // A pending offer is pinned to its core until the handshake completes.
  assign offer_on  = (state == RUN) &&
                     (offer_act || (free_any && next_nonce < NN));
  assign offer_sel = offer_act ? offer_idx : free_idx;

  always_comb begin
    req_valid = '0;
    if (offer_on) req_valid[offer_sel] = 1'b1;
  end

  assign req_nonce = offer_on ? 32'(next_nonce) : 32'h0;
  assign xfer      = |(req_valid & req_ready);

  assign arb_req   = (state == RUN) ? (res_valid & busy) : '0;
  assign res_ready = gnt;
  assign accept    = |gnt;

  rr_arbiter #(.N(INSTANCES)) u_arb (
    .clk   (clk),
    .rst_n (reset_n),
    .req   (arb_req),
    .adv   (accept),
    .gnt   (gnt),
    .last  (last)
  );

  always_comb begin
    acc_data = '0;
    for (int i = 0; i < INSTANCES; i++) begin
      if (gnt[i]) acc_data = res_data[32*i +: 32];
    end
  end

  // The written slot keeps its tag through the write cycle.
  assign memory_addr = base + tag[last];
  assign done        = (state == IDLE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = RUN;
      RUN:  if (mem_we && written == NN - CW'(1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base              <= '0;
      next_nonce        <= '0;
      written           <= '0;
      busy              <= '0;
      offer_act         <= 1'b0;
      offer_idx         <= '0;
      mem_we            <= 1'b0;
      memory_write_data <= '0;
      protocol_err      <= 1'b0;
      for (int i = 0; i < INSTANCES; i++) tag[i] <= '0;
    end else begin
      mem_we <= accept;
      if (accept) memory_write_data <= acc_data;
      if (state == IDLE) begin
        offer_act <= 1'b0;
        if (start) begin
          base         <= hash_out_addr;
          next_nonce   <= '0;
          written      <= '0;
          busy         <= '0;
          protocol_err <= 1'b0;
        end
      end else begin
        offer_act <= offer_on && !xfer;
        offer_idx <= offer_sel;
        busy      <= (busy & ~gnt) | (req_valid & req_ready);
        if (xfer) begin
          tag[offer_sel] <= next_nonce[15:0];
          next_nonce     <= next_nonce + CW'(1);
        end
        if (mem_we) written <= written + CW'(1);
        if (|(res_valid & ~busy)) protocol_err <= 1'b1;
      end
    end
  end

`ifdef NONCE_SCHED_MIN_TRACK_EN
  // Strict compare keeps the earlier write on a tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      min_hash  <= MIN_HASH_INIT;
      min_nonce <= '0;
    end else if (state == IDLE && start) begin
      min_hash  <= MIN_HASH_INIT;
      min_nonce <= '0;
    end else if (mem_we && memory_write_data < min_hash) begin
      min_hash  <= memory_write_data;
      min_nonce <= {16'h0, tag[last]};
    end
  end
`endif

endmodule
